// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - Shared types, defaults and next-bit function for the XNOR m-sequence generator and checker
package lfsr_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int             LFSR_N     = 10;
  localparam logic [9:0]     LFSR_TAPS  = 10'h240;
  localparam int             LFSR_MAX_N = 32;

  // Callers zero-extend h and taps, so any length up to LFSR_MAX_N shares this function.
  function automatic logic lfsr_next_bit(input logic [LFSR_MAX_N-1:0] h,
                                         input logic [LFSR_MAX_N-1:0] taps);
    return ~^(h & taps);
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// rtl/lfsr_checker_if.sv - Serial bit input, counter clear and status/counter outputs of lfsr_checker
interface lfsr_checker_if #(
  parameter int CW = 32
);
  logic          bit_in;
  logic          bit_valid;
  logic          clr_cnt;
  logic          locked;
  logic          err_pulse;
  logic          lock_lost;
  logic [CW-1:0] err_count;
  logic [CW-1:0] bit_count;

  modport master (
    output bit_in, bit_valid, clr_cnt,
    input  locked, err_pulse, lock_lost, err_count, bit_count
  );

  modport slave (
    input  bit_in, bit_valid, clr_cnt,
    output locked, err_pulse, lock_lost, err_count, bit_count
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - Saturating up-counter whose clear still counts a same-cycle increment
module sat_counter #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= CW'(inc);
    end else if (inc && (q != '1)) begin
      q <= q + CW'(1);
    end
  end
endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - Receive-side PRBS checker: self-syncs to the XNOR m-sequence, locks,
// then free-runs its local copy so each line error is counted exactly once.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int           N          = LFSR_N,
  parameter logic [N-1:0] TAPS       = N'(LFSR_TAPS),
  parameter int           LOCK_CNT   = 16,
  parameter int           ERR_WIN    = 64,
  parameter int           ERR_THRESH = 8,
  parameter int           CW         = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  lfsr_checker_if.slave bus
);
  localparam int FW = $clog2(N + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(ERR_WIN + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);

  state_t        state, state_d;
  logic [N-1:0]  h, h_d;
  logic [FW-1:0] fill_cnt, fill_d;
  logic [MW-1:0] match_cnt, match_d;
  logic [BW-1:0] win_bits, win_bits_d;
  logic [EW-1:0] win_errs, win_errs_d, win_errs_inc;
  logic          err_pulse_q, lock_lost_q;
  logic          err_ev, bit_ev, lost;
  logic          pred, mis;

  assign pred         = lfsr_next_bit(LFSR_MAX_N'(h), LFSR_MAX_N'(TAPS));
  assign mis          = (bus.bit_in != pred);
  assign win_errs_inc = win_errs + EW'(mis);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      h           <= '0;
      fill_cnt    <= '0;
      match_cnt   <= '0;
      win_bits    <= '0;
      win_errs    <= '0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state       <= state_d;
      h           <= h_d;
      fill_cnt    <= fill_d;
      match_cnt   <= match_d;
      win_bits    <= win_bits_d;
      win_errs    <= win_errs_d;
      err_pulse_q <= err_ev;
      lock_lost_q <= lost;
    end
  end

  always_comb begin
    state_d    = state;
    h_d        = h;
    fill_d     = fill_cnt;
    match_d    = match_cnt;
    win_bits_d = win_bits;
    win_errs_d = win_errs;
    err_ev     = 1'b0;
    bit_ev     = 1'b0;
    lost       = 1'b0;
    if (bus.bit_valid) begin
      unique case (state)
        FILL: begin
          h_d = {h[N-2:0], bus.bit_in};
          if (fill_cnt == FW'(N - 1)) begin
            state_d = VERIFY;
            fill_d  = '0;
          end else begin
            fill_d = fill_cnt + FW'(1);
          end
        end
        VERIFY: begin
          h_d = {h[N-2:0], bus.bit_in};
          // All-ones history is the XNOR lock-up state; it predicts 1 forever, so it never counts.
          if (!mis && (h != '1)) begin
            if (match_cnt == MW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              match_d = '0;
            end else begin
              match_d = match_cnt + MW'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          h_d    = {h[N-2:0], pred};
          bit_ev = 1'b1;
          err_ev = mis;
          if (win_errs_inc >= EW'(ERR_THRESH)) begin
            state_d    = FILL;
            fill_d     = '0;
            match_d    = '0;
            win_bits_d = '0;
            win_errs_d = '0;
            lost       = 1'b1;
          end else if (win_bits == BW'(ERR_WIN - 1)) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits + BW'(1);
            win_errs_d = win_errs_inc;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  sat_counter #(.CW(CW)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_ev),
    .clr   (bus.clr_cnt),
    .q     (bus.err_count)
  );

  sat_counter #(.CW(CW)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bit_ev),
    .clr   (bus.clr_cnt),
    .q     (bus.bit_count)
  );

  assign bus.locked    = (state == LOCKED);
  assign bus.err_pulse = err_pulse_q;
  assign bus.lock_lost = lock_lost_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - Table-driven scenarios plus randomized traffic for lfsr_checker
module tb_lfsr_checker;
  localparam int           N          = 10;
  localparam logic [N-1:0] TAPS       = 10'h240;
  localparam int           LOCK_CNT   = 16;
  localparam int           ERR_WIN    = 64;
  localparam int           ERR_THRESH = 8;
  localparam logic [63:0]  MAX32      = 64'hFFFF_FFFF;
  localparam logic [63:0]  MAX4       = 64'hF;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lfsr_checker_if #(.CW(32)) bus ();
  lfsr_checker_if #(.CW(4))  bus4 ();

  lfsr_checker #(.N(N), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .ERR_WIN(ERR_WIN),
                 .ERR_THRESH(ERR_THRESH), .CW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  lfsr_checker #(.N(N), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .ERR_WIN(ERR_WIN),
                 .ERR_THRESH(ERR_THRESH), .CW(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: mode 0 = filling, 1 = verifying, 2 = locked; histories newest at index 0.
  int          m_mode, m_fill, m_match, m_wbits, m_werrs;
  bit          m_hist[$];
  logic [63:0] m_err, m_bits, m_err4, m_bits4;
  bit          m_pulse, m_lost;
  bit          g_hist[$];
  int          g_idx;

  typedef struct {
    string       name;
    int          rst;
    int          nbits;
    int          src;
    int          inv_at;
    int          inv_len;
    int          clr_at;
    bit          gaps;
    bit          exp_locked;
    logic [63:0] exp_err;
    logic [63:0] exp_bits;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit predict(input bit q[$]);
    bit x = 1'b0;
    for (int k = 0; k < N; k++) if (TAPS[k]) x ^= q[k];
    return !x;
  endfunction

  function automatic logic [63:0] sat_upd(input logic [63:0] c, input bit ev, input bit clr,
                                          input logic [63:0] mx);
    if (clr) return {63'd0, ev};
    if (ev && c < mx) return c + 64'd1;
    return c;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_match = 0; m_wbits = 0; m_werrs = 0;
    m_err = 0; m_bits = 0; m_err4 = 0; m_bits4 = 0; m_pulse = 0; m_lost = 0;
    m_hist.delete();
    for (int i = 0; i < N; i++) m_hist.push_back(1'b0);
  endtask

  task automatic gen_reset();
    g_hist.delete();
    for (int i = 0; i < N; i++) g_hist.push_back(1'b0);
    g_idx = 0;
  endtask

  // Generator starts from all-zeros: N zeros come out before the first computed bit.
  task automatic gen_next(output bit o);
    o = (g_idx < N) ? 1'b0 : predict(g_hist);
    g_hist.push_front(o);
    void'(g_hist.pop_back());
    g_idx++;
  endtask

  task automatic push_hist(input bit x);
    m_hist.push_front(x);
    void'(m_hist.pop_back());
  endtask

  task automatic model_step(input bit v, input bit b, input bit c);
    bit ev_e, ev_b, p, all1;
    ev_e = 0; ev_b = 0; m_pulse = 0; m_lost = 0;
    if (v) begin
      p = predict(m_hist);
      all1 = 1;
      foreach (m_hist[i]) if (!m_hist[i]) all1 = 0;
      if (m_mode == 0) begin
        push_hist(b);
        m_fill++;
        if (m_fill == N) begin m_mode = 1; m_fill = 0; end
      end else if (m_mode == 1) begin
        if (b == p && !all1) m_match++; else m_match = 0;
        push_hist(b);
        if (m_match == LOCK_CNT) begin m_mode = 2; m_match = 0; end
      end else begin
        ev_b = 1;
        if (b != p) begin ev_e = 1; m_pulse = 1; m_werrs++; end
        push_hist(p);
        m_wbits++;
        if (m_werrs >= ERR_THRESH) begin
          m_mode = 0; m_fill = 0; m_match = 0; m_wbits = 0; m_werrs = 0; m_lost = 1;
        end else if (m_wbits == ERR_WIN) begin
          m_wbits = 0; m_werrs = 0;
        end
      end
    end
    m_err   = sat_upd(m_err,   ev_e, c, MAX32);
    m_bits  = sat_upd(m_bits,  ev_b, c, MAX32);
    m_err4  = sat_upd(m_err4,  ev_e, c, MAX4);
    m_bits4 = sat_upd(m_bits4, ev_b, c, MAX4);
  endtask

  task automatic compare_all();
    chk("locked",     bus.locked,     {63'd0, m_mode == 2});
    chk("err_pulse",  bus.err_pulse,  {63'd0, m_pulse});
    chk("lock_lost",  bus.lock_lost,  {63'd0, m_lost});
    chk("err_count",  bus.err_count,  m_err);
    chk("bit_count",  bus.bit_count,  m_bits);
    chk("err_count4", bus4.err_count, m_err4);
    chk("bit_count4", bus4.bit_count, m_bits4);
  endtask

  task automatic drive(input bit v, input bit b, input bit c);
    bus.bit_valid = v;  bus.bit_in = b;  bus.clr_cnt = c;
    bus4.bit_valid = v; bus4.bit_in = b; bus4.clr_cnt = c;
  endtask

  task automatic cycle(input bit v, input bit b, input bit c);
    @(negedge clk);
    drive(v, b, c);
    @(posedge clk);
    cyc++;
    model_step(v, b, c);
    #1;
    compare_all();
  endtask

  // src: 0 = generator stream (optionally inverted), 1 = stuck at 1, 2 = stuck at 0.
  task automatic send(input bit v, input bit inv, input bit c, input int src);
    bit b;
    if (v) begin
      if (src == 0) begin gen_next(b); b ^= inv; end
      else b = (src == 1);
    end else begin
      b = 1'($urandom_range(1));
    end
    cycle(v, b, c);
  endtask

  // Reset is dropped between clock edges so the zero check proves it acts asynchronously.
  task automatic do_reset(input bit full);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_locked",     bus.locked,     64'd0);
    chk("rst_err_pulse",  bus.err_pulse,  64'd0);
    chk("rst_lock_lost",  bus.lock_lost,  64'd0);
    chk("rst_err_count",  bus.err_count,  64'd0);
    chk("rst_bit_count",  bus.bit_count,  64'd0);
    chk("rst_err_count4", bus4.err_count, 64'd0);
    chk("rst_bit_count4", bus4.bit_count, 64'd0);
    model_reset();
    if (full) gen_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rates[4];
    int r;
    bit v, inv, c;

    drive(1'b0, 1'b0, 1'b0);
    model_reset();
    gen_reset();

    //            name          rst nbits src inv_at len clr gaps lk err bits
    tbl[0]  = '{"lock_a",      1,  25,  0,  -1,   0, -1,  0,  0,  0,  0};
    tbl[1]  = '{"lock_b",      0,  1,   0,  -1,   0, -1,  0,  1,  0,  0};
    tbl[2]  = '{"run100",      0,  100, 0,  -1,   0, -1,  0,  1,  0,  100};
    tbl[3]  = '{"single_err",  0,  20,  0,  5,    1, -1,  0,  1,  1,  120};
    tbl[4]  = '{"win_end",     0,  8,   0,  -1,   0, -1,  0,  1,  1,  128};
    tbl[5]  = '{"clr_err",     0,  1,   0,  0,    1, 0,   0,  1,  1,  1};
    tbl[6]  = '{"win_fill",    0,  63,  0,  -1,   0, -1,  0,  1,  1,  64};
    tbl[7]  = '{"burst8",      0,  8,   0,  0,    8, 0,   0,  0,  8,  8};
    tbl[8]  = '{"relock_a",    0,  25,  0,  -1,   0, -1,  0,  0,  8,  8};
    tbl[9]  = '{"relock_b",    0,  1,   0,  -1,   0, -1,  0,  1,  8,  8};
    tbl[10] = '{"stuck1",      1,  200, 1,  -1,   0, -1,  0,  0,  0,  0};
    tbl[11] = '{"stuck0",      0,  200, 2,  -1,   0, -1,  0,  0,  0,  0};
    tbl[12] = '{"gap_lock",    1,  26,  0,  -1,   0, -1,  1,  1,  0,  0};
    tbl[13] = '{"gap_run",     0,  100, 0,  5,    1, -1,  1,  1,  1,  100};
    tbl[14] = '{"areset_a",    2,  25,  0,  -1,   0, -1,  0,  0,  0,  0};
    tbl[15] = '{"areset_b",    0,  1,   0,  -1,   0, -1,  0,  1,  0,  0};

    foreach (tbl[t]) begin
      if (tbl[t].rst != 0) do_reset(tbl[t].rst == 1);
      for (int i = 0; i < tbl[t].nbits; i++) begin
        if (tbl[t].gaps) while ($urandom_range(1) == 0) send(1'b0, 1'b0, 1'b0, 0);
        send(1'b1, (i >= tbl[t].inv_at) && (i < tbl[t].inv_at + tbl[t].inv_len),
             (i == tbl[t].clr_at), tbl[t].src);
      end
      chk({tbl[t].name, "_locked"}, bus.locked,    {63'd0, tbl[t].exp_locked});
      chk({tbl[t].name, "_err"},    bus.err_count, tbl[t].exp_err);
      chk({tbl[t].name, "_bits"},   bus.bit_count, tbl[t].exp_bits);
    end

    // Randomized traffic: error density changes per segment so lock is gained and lost repeatedly.
    rates[0] = 0; rates[1] = 64; rates[2] = 8; rates[3] = 3;
    do_reset(1'b1);
    for (int seg = 0; seg < 8; seg++) begin
      r = rates[$urandom_range(3)];
      for (int i = 0; i < 500; i++) begin
        v   = ($urandom_range(3) != 0);
        inv = (r != 0) && ($urandom_range(r - 1) == 0);
        c   = ($urandom_range(99) == 0);
        send(v, inv, c, 0);
      end
      if ($urandom_range(2) == 0) do_reset(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Receive-side checker for the team's XNOR m-sequence generator. It takes a serial PRBS bit stream, self-synchronises a local copy of the generator's recurrence, declares lock, and then free-runs to count bit errors once each. It sits at the far end of a link or loopback under test and feeds status and error counters to software.

Parameters:
N, 10, LFSR length in bits.
TAPS, 10'h240, tap mask in bit positions [N:1]; matches the generator's mask.
LOCK_CNT, 16, consecutive correct predictions required to declare lock (>=1).
ERR_WIN, 64, size in valid bits of the loss-of-lock observation window.
ERR_THRESH, 8, errors within one window that force loss of lock (1 <= ERR_THRESH <= ERR_WIN).
CW, 32, width of the error and bit counters.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
bit_in  in  1  received sequence bit.
bit_valid  in  1  bit_in is sampled only on cycles where this is high.
clr_cnt  in  1  synchronous clear of err_count and bit_count.
locked  out  1  checker is in LOCKED.
err_pulse  out  1  one-cycle pulse: the previous valid bit mismatched while LOCKED.
lock_lost  out  1  one-cycle pulse on the LOCKED -> FILL transition.
err_count  out  CW  errors counted while LOCKED; saturates at all-ones.
bit_count  out  CW  bits compared while LOCKED; saturates at all-ones.

Behaviour:
- Sequence definition: s[n] = ~XOR over k in TAPS of s[n-k].
- History register h[N:1] holds the past bits, with h[1] the newest. The predicted bit is p = ~^(h & TAPS). A shift is h <= {h[N-1:1], x}.
- Reset: state FILL, h = 0, fill and match counters 0, window counters 0. All outputs are 0.
- Cycles with bit_valid low: no state or counter change. err_pulse and lock_lost are 0.
- FILL state:
  - On each valid bit, shift with x = bit_in and increment the fill counter.
  - The N-th valid bit moves the block to VERIFY.
- VERIFY state:
  - On each valid bit, shift with x = bit_in (self-sync).
  - If bit_in == p and h != all-ones, increment the match counter.
  - Otherwise, clear the match counter. The all-ones guard rejects the XNOR lock-up state, so a stuck-at-1 line never locks.
  - The LOCK_CNT-th consecutive match moves the block to LOCKED. locked is registered and goes high on the same edge.
- LOCKED state:
  - On each valid bit, shift with x = p (free-run, no error multiplication).
  - bit_count increments on every valid bit.
  - On a mismatch (bit_in != p), err_pulse = 1 for the following cycle, err_count increments, and the window error count increments.
  - The window bit counter runs 0..ERR_WIN-1. The window error count is compared against ERR_THRESH after including the current bit; the window is cleared after that comparison when the counter wraps.
  - If the window error count reaches ERR_THRESH, the block moves to FILL: fill, match and window counters clear, locked = 0, and lock_lost pulses for one cycle. h is not cleared.
- Counters:
  - Both counters saturate and do not wrap.
  - When clr_cnt is high, the counter loads (event this cycle ? 1 : 0). Clear wins over the old value, but the same-cycle event is still counted.
  - Counters are unaffected by state changes. Only reset and clr_cnt clear them.
- Reset asserted mid-operation returns the block to the reset values immediately (asynchronously).

Decomposition:
- lfsr_pkg holds:
  - the state enum {FILL, VERIFY, LOCKED};
  - the default N and TAPS;
  - the function lfsr_next_bit(h, taps) returning ~^(h & taps), shared with the generator.
- One sub-module is natural: sat_counter #(CW), with inputs inc and clr and output q, saturating. It is instantiated twice, for err_count and bit_count.

Test Plan:
- Generator reset to all-zeros feeds the checker with bit_valid held high, so the first stream bits are ten 0s then 1. Required: FILL absorbs bits 0-9; VERIFY matches bits 10-25; locked rises on the edge sampling bit 25; err_count stays 0; bit_count = 100 after 100 further bits.
- Single inverted bit while LOCKED. Required: one err_pulse, err_count = 1, locked stays 1, with no follow-on errors (not 3, as a self-sync checker would report).
- Burst of 8 inverted bits within one 64-bit window. Required: lock_lost pulses on the 8th error and locked falls; relock occurs exactly 26 valid bits later; err_count = 8.
- bit_in held at 1 for 200 bits, then held at 0 for 200 bits. Required: locked never asserts and the counters stay 0.
- clr_cnt asserted on the same cycle as an error bit. Required: err_count = 1 and bit_count = 1 afterwards.
- bit_valid toggled randomly at 50% while LOCKED. Required: counts identical to the gap-free run. Then assert rst_n low while LOCKED: all outputs 0 immediately, and relock takes 26 valid bits.
